// File: rtl/sync_data_memory_pkg.sv
// Shared definitions for the sync_data_memory block: FSM encoding and default sizing.
package sync_data_memory_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DEPTH  = 1024;

    // Width of an index into a DEPTH-word array; never narrower than one bit.
    function automatic int ptrWidth(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mem_array_be.sv
// Single-port DATA_W x DEPTH storage with per-byte write enables and a registered read.
// Kept free of control logic so it can be replaced by a vendor block RAM.
module mem_array_be #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 1024,
    parameter int AW     = 10
) (
    input  logic                  clk,
    input  logic                  wrEn,
    input  logic                  rdEn,
    input  logic [DATA_W/8-1:0]   wrBe,
    input  logic [AW-1:0]         addr,
    input  logic [DATA_W-1:0]     wrData,
    output logic [DATA_W-1:0]     rdData
);

    localparam int BE_W = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];

    // Byte-lane write and registered read; the read register holds when rdEn is low.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            for (int k = 0; k < BE_W; k++) begin
                if (wrBe[k]) begin
                    mem[addr][8*k +: 8] <= wrData[8*k +: 8];
                end
            end
        end
        if (rdEn) begin
            rdData <= mem[addr];
        end
    end

endmodule

// File: rtl/sync_data_memory.sv
// Data memory for the accumulator datapath: zeroing sweep after reset or on request,
// then single-port byte-enabled writes and latency-1 reads with range checking.
//
// state    | meaning
// ST_CLEAR | sweep writes zero to one word per cycle, port not ready
// ST_RUN   | port ready, accepts req / clear_req
module sync_data_memory
    import sync_data_memory_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_req,
    input  logic                  req,
    input  logic                  MemWrite,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [ADDR_W-1:0]     addra,
    input  logic [DATA_W-1:0]     DataWrite,
    output logic                  ready,
    output logic [DATA_W-1:0]     DataOut,
    output logic                  rvalid,
    output logic                  err
);

    localparam int BE_W = DATA_W / 8;
    localparam int AW   = ptrWidth(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_X  = (ADDR_W+1)'(DEPTH);
    localparam logic [AW-1:0]   LAST_PTR = AW'(DEPTH - 1);

    state_t            state, stateNext;
    logic [AW-1:0]     clrPtr;
    logic              accept, inRange;
    logic              memWe, memRe;
    logic [BE_W-1:0]   memBe;
    logic [AW-1:0]     memAddr;
    logic [DATA_W-1:0] memWData, memRData;
    // Forces DataOut to zero after reset and after an out-of-range read, without
    // needing a reset on the RAM's own read register.
    logic              zeroOut;

    assign inRange = {1'b0, addra} < DEPTH_X;
    assign accept  = req && ready;
    assign DataOut = zeroOut ? '0 : memRData;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_CLEAR;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state: leave the sweep after the last word, re-enter it on clear_req.
    always_comb begin
        stateNext = state;
        case (state)
            ST_CLEAR: if (clrPtr == LAST_PTR) stateNext = ST_RUN;
            ST_RUN:   if (clear_req)          stateNext = ST_CLEAR;
            default:  stateNext = ST_CLEAR;
        endcase
    end

    // Outputs and RAM port steering: sweep owns the port in CLEAR, caller in RUN.
    always_comb begin
        ready    = 1'b0;
        memWe    = 1'b0;
        memRe    = 1'b0;
        memBe    = '1;
        memAddr  = clrPtr;
        memWData = '0;
        case (state)
            ST_CLEAR: begin
                memWe = 1'b1;
            end
            ST_RUN: begin
                ready    = 1'b1;
                memAddr  = addra[AW-1:0];
                memWData = DataWrite;
                memBe    = be;
                memWe    = req && MemWrite && inRange;
                memRe    = req && !MemWrite && inRange;
            end
            default: ;
        endcase
    end

    // Sweep pointer: advances every CLEAR cycle, rewinds when a clear is requested.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clrPtr <= '0;
        end else if (state == ST_CLEAR) begin
            clrPtr <= clrPtr + AW'(1);
        end else if (clear_req) begin
            clrPtr <= '0;
        end
    end

    // One-cycle rvalid/err pulses and the zero-mask for out-of-range reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid  <= 1'b0;
            err     <= 1'b0;
            zeroOut <= 1'b1;
        end else begin
            rvalid <= accept && !MemWrite;
            err    <= accept && !inRange;
            if (accept && !MemWrite) begin
                zeroOut <= !inRange;
            end
        end
    end

    mem_array_be #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) uArray (
        .clk    (clk),
        .wrEn   (memWe),
        .rdEn   (memRe),
        .wrBe   (memBe),
        .addr   (memAddr),
        .wrData (memWData),
        .rdData (memRData)
    );

endmodule

// File: tb/tb_sync_data_memory.sv
// Bench for sync_data_memory: a DEPTH=1000 instance checked every cycle against a
// word-array model, plus a DEPTH=1024 instance for the default-size sweep timing.
module tb_sync_data_memory;

    localparam int D  = 1000;
    localparam int DB = 1024;

    logic        clk = 1'b0;
    logic        rst_n, clear_req, req, MemWrite;
    logic [1:0]  be;
    logic [15:0] addra, DataWrite;
    logic        ready, rvalid, err;
    logic [15:0] DataOut;
    logic        readyB, rvalidB, errB;
    logic [15:0] DataOutB;

    int total  = 0;
    int passed = 0;
    logic chkEn = 1'b0;

    always #5 clk = ~clk;

    sync_data_memory #(.DATA_W(16), .ADDR_W(16), .DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .req(req), .MemWrite(MemWrite),
        .be(be), .addra(addra), .DataWrite(DataWrite), .ready(ready), .DataOut(DataOut),
        .rvalid(rvalid), .err(err)
    );

    sync_data_memory #(.DATA_W(16), .ADDR_W(16), .DEPTH(DB)) dutBig (
        .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .req(req), .MemWrite(MemWrite),
        .be(be), .addra(addra), .DataWrite(DataWrite), .ready(readyB), .DataOut(DataOutB),
        .rvalid(rvalidB), .err(errB)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: a plain word array, a count of sweep cycles left, and the expected outputs.
    logic [15:0] mdl [D];
    int          clearLeft;
    logic        expRv, expErr;
    logic [15:0] expData;

    function automatic logic [15:0] laneMask(input logic [1:0] b);
        return (b[0] ? 16'h00FF : 16'h0000) | (b[1] ? 16'hFF00 : 16'h0000);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clearLeft <= D;
            expRv     <= 1'b0;
            expErr    <= 1'b0;
            expData   <= '0;
            for (int i = 0; i < D; i++) mdl[i] <= '0;
        end else begin
            expRv  <= 1'b0;
            expErr <= 1'b0;
            if (clearLeft > 0) begin
                clearLeft <= clearLeft - 1;
            end else begin
                if (req) begin
                    if (int'(addra) < D) begin
                        if (MemWrite)
                            mdl[addra] <= (mdl[addra] & ~laneMask(be)) | (DataWrite & laneMask(be));
                        else
                            expData <= mdl[addra];
                    end else begin
                        expErr <= 1'b1;
                        if (!MemWrite) expData <= '0;
                    end
                    if (!MemWrite) expRv <= 1'b1;
                end
                if (clear_req) begin
                    clearLeft <= D;
                    for (int i = 0; i < D; i++) mdl[i] <= '0;
                end
            end
        end
    end

    // Every-cycle comparison of the DEPTH=1000 instance against the model.
    always @(negedge clk) begin
        if (chkEn) begin
            check("ready",   ready,   clearLeft == 0);
            check("rvalid",  rvalid,  expRv);
            check("err",     err,     expErr);
            check("DataOut", DataOut, expData);
        end
    end

    task automatic access(input logic w, input logic [1:0] b, input logic [15:0] a,
                          input logic [15:0] d, output logic [15:0] q, output logic v,
                          output logic e, output logic [15:0] qB, output logic vB);
        @(negedge clk);
        req = 1'b1; MemWrite = w; be = b; addra = a; DataWrite = d;
        @(posedge clk); #1;
        q = DataOut; v = rvalid; e = err; qB = DataOutB; vB = rvalidB;
        req = 1'b0;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [15:0] q, qB;
        logic        v, e, vB;
        int          n, nB;

        rst_n = 1'b0; clear_req = 1'b0; req = 1'b0; MemWrite = 1'b0;
        be = 2'b00; addra = '0; DataWrite = '0;
        repeat (3) @(posedge clk);
        chkEn = 1'b1;

        // Sweep timing after reset release for both sizes.
        @(negedge clk); #1 rst_n = 1'b1;
        n = 0; nB = 0;
        for (int c = 1; c <= 2000 && (n == 0 || nB == 0); c++) begin
            @(posedge clk); #1;
            if (ready  && n  == 0) n  = c;
            if (readyB && nB == 0) nB = c;
        end
        check("ready_rise_1000", n, 1000);
        check("ready_rise_1024", nB, 1024);

        access(1'b0, 2'b00, 16'd0, 16'd0, q, v, e, qB, vB);
        check("big_rd0_data", qB, 16'h0000);
        check("big_rd0_rvalid", vB, 1'b1);
        access(1'b0, 2'b00, 16'd1023, 16'd0, q, v, e, qB, vB);
        check("big_rd1023_data", qB, 16'h0000);
        check("big_rd1023_rvalid", vB, 1'b1);
        check("rd1023_oor_err", e, 1'b1);

        // Write-then-read table.
        for (int k = 0; k <= 10; k++)
            access(1'b1, 2'b11, 16'(2*k), 16'(k*100), q, v, e, qB, vB);
        for (int k = 0; k <= 10; k++) begin
            access(1'b0, 2'b00, 16'(2*k), 16'd0, q, v, e, qB, vB);
            check("tbl_data", q, 16'(k*100));
            check("tbl_rvalid", v, 1'b1);
        end
        @(posedge clk); #1;
        check("rvalid_one_cycle", rvalid, 1'b0);

        // Byte-lane merge and the no-op write.
        access(1'b1, 2'b11, 16'd5, 16'h1234, q, v, e, qB, vB);
        check("write_no_rvalid", v, 1'b0);
        access(1'b1, 2'b10, 16'd5, 16'hABCD, q, v, e, qB, vB);
        access(1'b0, 2'b00, 16'd5, 16'd0, q, v, e, qB, vB);
        check("be10_merge", q, 16'hAB34);
        access(1'b1, 2'b00, 16'd5, 16'hFFFF, q, v, e, qB, vB);
        access(1'b0, 2'b00, 16'd5, 16'd0, q, v, e, qB, vB);
        check("be00_noop", q, 16'hAB34);

        // Out-of-range accesses.
        access(1'b1, 2'b11, 16'd0, 16'h0A0A, q, v, e, qB, vB);
        access(1'b1, 2'b11, 16'd1000, 16'h5555, q, v, e, qB, vB);
        check("oor_wr_err", e, 1'b1);
        access(1'b0, 2'b00, 16'd1000, 16'd0, q, v, e, qB, vB);
        check("oor_rd_err", e, 1'b1);
        check("oor_rd_rvalid", v, 1'b1);
        check("oor_rd_data", q, 16'h0000);
        access(1'b0, 2'b00, 16'd0, 16'd0, q, v, e, qB, vB);
        check("oor_mem0_kept", q, 16'h0A0A);
        check("inrange_no_err", e, 1'b0);

        // Randomised traffic, mostly a small window plus the range edge.
        for (int i = 0; i < 400; i++) begin
            logic [15:0] a;
            a = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(990, 1023))
                                            : 16'($urandom_range(0, 31));
            access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a,
                   16'($urandom), q, v, e, qB, vB);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        // clear_req with a simultaneous read: read served first, then full sweep.
        access(1'b1, 2'b11, 16'd7, 16'hBEEF, q, v, e, qB, vB);
        @(negedge clk);
        clear_req = 1'b1; req = 1'b1; MemWrite = 1'b0; addra = 16'd7;
        @(posedge clk); #1;
        check("clr_same_cycle_data", DataOut, 16'hBEEF);
        check("clr_same_cycle_rvalid", rvalid, 1'b1);
        check("clr_ready_drop", ready, 1'b0);
        clear_req = 1'b0; req = 1'b0;
        n = 0;
        for (int c = 1; c <= 2000; c++) begin
            @(posedge clk); #1;
            if (ready) begin n = c; break; end
        end
        check("clear_ready_low", n, 1000);
        access(1'b0, 2'b00, 16'd7, 16'd0, q, v, e, qB, vB);
        check("cleared_word7", q, 16'h0000);

        // Reset in the middle of a sweep, with a write held while not ready.
        access(1'b1, 2'b11, 16'd3, 16'h1111, q, v, e, qB, vB);
        @(negedge clk); clear_req = 1'b1;
        @(posedge clk); #1 clear_req = 1'b0;
        repeat (300) @(posedge clk);
        #1 rst_n = 1'b0;
        req = 1'b1; MemWrite = 1'b1; be = 2'b11; addra = 16'd3; DataWrite = 16'h2222;
        repeat (2) @(posedge clk);
        @(negedge clk); #1 rst_n = 1'b1;
        n = 0; nB = 0;
        for (int c = 1; c <= 2000 && (n == 0 || nB == 0); c++) begin
            @(posedge clk); #1;
            if (ready && n == 0) begin n = c; req = 1'b0; end
            if (readyB && nB == 0) nB = c;
        end
        req = 1'b0;
        check("rst_mid_ready_low", n, 1000);
        check("rst_mid_ready_low_big", nB, 1024);
        access(1'b0, 2'b00, 16'd3, 16'd0, q, v, e, qB, vB);
        check("held_req_ignored", q, 16'h0000);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
